ram_sdp_init: RTL and testbench

Parametrised simple-dual-port RAM: one write port and one registered read port. After every reset or soft-clear request, an internal sweep zeroes the whole array. It is the next-generation storage primitive of the register block, replacing fixed 128x4 single-port storage where concurrent read/write and a guaranteed-clean start are needed.

---
 rtl/ram_sdp_init.sv | 94 +++++++++
 tb/tb_ram_sdp_init.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ram_sdp_init.sv
// Simple-dual-port RAM that zeroes the whole array after reset or clr before opening its ports.
// Optional macro RAM_SDP_BYPASS_EN selects write-first collisions; the default is read-first.
module ram_sdp_init #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              init_done,
  output logic              err
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {INIT, READY} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] rd_word;

  // Single write port shared by the zeroing sweep and the user write; clr drops both.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = wr_addr;
    mem_din  = wr_data;
    if (rst && !clr) begin
      if (state == INIT) begin
        mem_we   = 1'b1;
        mem_addr = cnt;
        mem_din  = '0;
      end else begin
        mem_we = wr_en;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_din;
    end
  end

`ifdef RAM_SDP_BYPASS_EN
  assign rd_word = (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
`else
  assign rd_word = mem[rd_addr];
`endif

  // cnt terminates on compare at the last address, so a finished sweep never restarts by itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= INIT;
      cnt       <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      init_done <= 1'b0;
      err       <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      err      <= 1'b0;
      if (clr) begin
        state     <= INIT;
        cnt       <= '0;
        init_done <= 1'b0;
      end else if (state == INIT) begin
        err <= wr_en | rd_en;
        if (cnt == '1) begin
          state     <= READY;
          init_done <= 1'b1;
          cnt       <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else if (rd_en) begin
        rd_data  <= rd_word;
        rd_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ram_sdp_init.sv
// Directed bench for ram_sdp_init with DATA_W=8, ADDR_W=4 (DEPTH=16).
// Collision expectation follows RAM_SDP_BYPASS_EN if the bench is built with it.
module tb_ram_sdp_init;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       init_done;
  logic       err;

  int checks = 0;
  int errors = 0;

  ram_sdp_init #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .init_done (init_done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input logic [3:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [3:0] a, input logic [7:0] exp);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
    check({tag, "_data"}, rd_data, exp);
    check({tag, "_valid"}, rd_valid, 1'b1);
    $display("read addr %0d data %02h", a, rd_data);
  endtask

  initial begin
    logic [7:0] coll_exp;
    rst = 1'b1; clr = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0;
    #2 rst = 1'b0;
    tick(); tick();
    check("reset_rd_data", rd_data, 8'h00);
    check("reset_rd_valid", rd_valid, 1'b0);
    check("reset_init_done", init_done, 1'b0);
    check("reset_err", err, 1'b0);

    // Reset sweep: release between edges so the next edge is edge 1.
    rst = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      tick();
      check($sformatf("sweep_init_done_e%0d", e), init_done, (e == 16) ? 1'b1 : 1'b0);
    end
    $display("sweep done after 16 edges, init_done %0b", init_done);
    for (int i = 0; i < 16; i++) read_check($sformatf("sweep_rd%0d", i), 4'(i), 8'h00);
    tick();
    check("idle_rd_valid", rd_valid, 1'b0);

    // Basic write then read, then hold.
    write_word(4'd3, 8'hA5);
    read_check("basic_rd", 4'd3, 8'hA5);
    tick();
    check("basic_hold_data", rd_data, 8'hA5);
    check("basic_hold_valid", rd_valid, 1'b0);

    // Independent ports on different addresses.
    wr_en = 1'b1; wr_addr = 4'd8; wr_data = 8'h33;
    read_check("indep_rd3", 4'd3, 8'hA5);
    wr_en = 1'b0;
    read_check("indep_rd8", 4'd8, 8'h33);

    // Same-address collision.
    write_word(4'd7, 8'h11);
`ifdef RAM_SDP_BYPASS_EN
    coll_exp = 8'h22;
`else
    coll_exp = 8'h11;
`endif
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 8'h22;
    read_check("collision_rd", 4'd7, coll_exp);
    wr_en = 1'b0;
    read_check("collision_after", 4'd7, 8'h22);

    // Soft clear with a concurrent write and read.
    for (int i = 0; i < 16; i++) write_word(4'(i), 8'h5A);
    read_check("fill_rd5", 4'd5, 8'h5A);
    clr = 1'b1; wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'hFF; rd_en = 1'b1; rd_addr = 4'd5;
    tick();
    clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    check("clr_init_done", init_done, 1'b0);
    check("clr_err", err, 1'b0);
    check("clr_rd_valid", rd_valid, 1'b0);
    check("clr_rd_data_hold", rd_data, 8'h5A);
    for (int e = 1; e <= 16; e++) begin
      tick();
      check($sformatf("clr_sweep_init_done_e%0d", e), init_done, (e == 16) ? 1'b1 : 1'b0);
      check($sformatf("clr_sweep_err_e%0d", e), err, 1'b0);
    end
    $display("soft clear sweep done, init_done %0b", init_done);
    for (int i = 0; i < 16; i++) read_check($sformatf("clr_rd%0d", i), 4'(i), 8'h00);

    // Reset while a read result is on the outputs.
    write_word(4'd4, 8'h5A);
    read_check("pre_rst_rd4", 4'd4, 8'h5A);
    rst = 1'b0;
    #1;
    check("async_rst_rd_data", rd_data, 8'h00);
    check("async_rst_rd_valid", rd_valid, 1'b0);
    check("async_rst_init_done", init_done, 1'b0);
    tick(); tick();
    rst = 1'b1;

    // Sweep after release, with an illegal write at edge 5.
    for (int e = 1; e <= 16; e++) begin
      if (e == 5) begin
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 8'hFF;
      end
      tick();
      wr_en = 1'b0;
      check($sformatf("rst_sweep_init_done_e%0d", e), init_done, (e == 16) ? 1'b1 : 1'b0);
      check($sformatf("rst_sweep_err_e%0d", e), err, (e == 5) ? 1'b1 : 1'b0);
      check($sformatf("rst_sweep_rd_valid_e%0d", e), rd_valid, 1'b0);
    end
    $display("reset sweep with init access done, init_done %0b", init_done);
    read_check("init_access_rd2", 4'd2, 8'h00);
    read_check("rst_swept_rd4", 4'd4, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
